limit_mode_ctrl: RTL and testbench

//  Parametrised successor of the counter's mode-select stage. Holds NUM_SLOTS

---
 rtl/limit_mode_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_limit_mode_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/limit_mode_ctrl.sv
// ---------------------------------------------------------------------------
// limit_mode_ctrl
//
// Mode-select stage for the BCD digit counter. Stores NUM_SLOTS digit-limit
// registers and runs a mode FSM (SINGLE / CARRY / MAX / STOP). Every mode
// change passes through a SETTLE phase of SETTLE_CYCLES clocks during which
// all outputs are held low. The limit bus and enables are a direct decode of
// registered state. limit_hit flags the first cycle the count reaches the
// active limit.
//
// Ports
//   clk            : system clock, rising edge
//   reset_n        : asynchronous reset, active low
//   cnt_in         : current counter digits (4*DIGITS bits, BCD)
//   refresh_limits : write clamped cnt_in into slot slot_sel
//   slot_sel       : slot index for refresh and mode requests
//   mode_req_valid : one-cycle mode request strobe
//   mode_req       : 00 single, 01 carry, 10 max, 11 stop
//   max_out        : limit / carry information for the counter
//   carry_en       : carry mode active
//   max_en         : max-value mode active
//   stop_en        : stop-at-limit mode active
//   mode_ack       : one-cycle pulse on entering the requested mode
//   limit_hit      : one-cycle pulse when the count first equals the limit
// ---------------------------------------------------------------------------
module limit_mode_ctrl #(
    parameter int DIGITS        = 6,
    parameter int NUM_SLOTS     = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_DIGIT     = 9,
    localparam int DW = 4 * DIGITS,
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] cnt_in,
    input  logic          refresh_limits,
    input  logic [SW-1:0] slot_sel,
    input  logic          mode_req_valid,
    input  logic [1:0]    mode_req,
    output logic [DW-1:0] max_out,
    output logic          carry_en,
    output logic          max_en,
    output logic          stop_en,
    output logic          mode_ack,
    output logic          limit_hit
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    // Low two bits of the steady states equal the mode_req encoding.
    localparam logic [2:0] ST_SINGLE = 3'd0;
    localparam logic [2:0] ST_CARRY  = 3'd1;
    localparam logic [2:0] ST_MAX    = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    localparam logic [SW:0] NUM_SLOTS_W = (SW + 1)'(NUM_SLOTS);
    localparam logic [3:0]  MAX_DIG     = 4'(MAX_DIGIT);

    function automatic logic [DW-1:0] clamp_digits(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int j = 0; j < DIGITS; j++) begin
            r[4*j +: 4] = (v[4*j +: 4] > MAX_DIG) ? MAX_DIG : v[4*j +: 4];
        end
        return r;
    endfunction

    logic [2:0]    state_q,  state_d;
    logic [1:0]    target_q, target_d;
    logic [SW-1:0] act_q,    act_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [DW-1:0] slots_q [NUM_SLOTS];
    logic [DW-1:0] slots_d [NUM_SLOTS];
    logic          ack_q,    ack_d;
    logic          match_q,  match_d;
    logic          hit_q,    hit_d;

    logic          slot_ok;
    logic          same_req;
    logic [DW-1:0] active_lim;

    assign slot_ok    = ({1'b0, slot_sel} < NUM_SLOTS_W);
    assign active_lim = slots_q[act_q];
    // A repeat of the running mode/slot is a no-op; inside SETTLE every valid
    // request retargets, even one naming the mode we came from.
    assign same_req   = (state_q != ST_SETTLE) && (mode_req == state_q[1:0]) &&
                        (slot_sel == act_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        act_d    = act_q;
        settle_d = settle_q;
        ack_d    = 1'b0;
        slots_d  = slots_q;

        if (mode_req_valid && slot_ok && !same_req) begin
            state_d  = ST_SETTLE;
            target_d = mode_req;
            act_d    = slot_sel;
            settle_d = CW'(SETTLE_CYCLES);
        end else if (state_q == ST_SETTLE) begin
            // Counter was loaded with SETTLE_CYCLES on entry; leaving on the
            // edge where it reads 1 gives exactly SETTLE_CYCLES low cycles.
            if (settle_q <= CW'(1)) begin
                state_d  = {1'b0, target_q};
                settle_d = '0;
                ack_d    = 1'b1;
            end else begin
                settle_d = settle_q - CW'(1);
            end
        end

        if (refresh_limits && slot_ok) begin
            slots_d[slot_sel] = clamp_digits(cnt_in);
        end

        // Match is suppressed in SETTLE, so re-entering a limit mode while
        // already at the limit produces a fresh pulse.
        match_d = ((state_q == ST_MAX) || (state_q == ST_STOP)) &&
                  (cnt_in == active_lim);
        hit_d   = match_d & ~match_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_SINGLE;
            target_q <= 2'b00;
            act_q    <= '0;
            settle_q <= '0;
            ack_q    <= 1'b0;
            match_q  <= 1'b0;
            hit_q    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            act_q    <= act_d;
            settle_q <= settle_d;
            ack_q    <= ack_d;
            match_q  <= match_d;
            hit_q    <= hit_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    always_comb begin
        max_out  = '0;
        carry_en = 1'b0;
        max_en   = 1'b0;
        stop_en  = 1'b0;
        case (state_q)
            ST_CARRY: begin
                carry_en = 1'b1;
                // One flag per digit on its LSB: digit participates in carry
                // only when its limit is non-zero.
                for (int j = 0; j < DIGITS; j++) begin
                    max_out[4*j] = |active_lim[4*j +: 4];
                end
            end
            ST_MAX: begin
                max_en  = 1'b1;
                max_out = active_lim;
            end
            ST_STOP: begin
                stop_en = 1'b1;
                max_out = active_lim;
            end
            default: begin
            end
        endcase
    end

    assign mode_ack  = ack_q;
    assign limit_hit = hit_q;

endmodule

// File: tb/tb_limit_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_limit_mode_ctrl
//
// Scoreboard bench for limit_mode_ctrl (DIGITS=6, NUM_SLOTS=2,
// SETTLE_CYCLES=2, MAX_DIGIT=9). A behavioural model advances on each clock
// edge and queues the expected outputs; a monitor pops one entry every
// falling edge and compares. Directed scenarios are followed by random
// traffic.
// ---------------------------------------------------------------------------
module tb_limit_mode_ctrl;

    localparam int DIGITS = 6;
    localparam int NSLOT  = 2;
    localparam int SETTLE = 2;

    logic        clk;
    logic        reset_n;
    logic [23:0] cnt_in;
    logic        refresh_limits;
    logic [0:0]  slot_sel;
    logic        mode_req_valid;
    logic [1:0]  mode_req;
    logic [23:0] max_out;
    logic        carry_en, max_en, stop_en, mode_ack, limit_hit;

    limit_mode_ctrl #(
        .DIGITS(DIGITS), .NUM_SLOTS(NSLOT), .SETTLE_CYCLES(SETTLE), .MAX_DIGIT(9)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cnt_in(cnt_in),
        .refresh_limits(refresh_limits), .slot_sel(slot_sel),
        .mode_req_valid(mode_req_valid), .mode_req(mode_req),
        .max_out(max_out), .carry_en(carry_en), .max_en(max_en),
        .stop_en(stop_en), .mode_ack(mode_ack), .limit_hit(limit_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] mo;
        logic c, m, s, a, h;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- behavioural model ----------------
    int m_mode, m_target, m_slot, m_left;
    bit m_settle, m_match_prev;
    int lim [NSLOT][DIGITS];

    function automatic logic [23:0] lim_val(input int s);
        int acc = 0;
        for (int d = 0; d < DIGITS; d++) acc += lim[s][d] << (4 * d);
        return 24'(acc);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_target = 0; m_slot = 0; m_left = 0;
            m_settle = 0; m_match_prev = 0;
            for (int s = 0; s < NSLOT; s++)
                for (int d = 0; d < DIGITS; d++) lim[s][d] = 0;
            sb.delete();
        end else begin
            exp_t e;
            bit   mn;
            bit   ack;
            int   dig;
            e   = '0;
            ack = 0;
            mn  = !m_settle && (m_mode == 2 || m_mode == 3) && (cnt_in == lim_val(m_slot));
            e.h = mn && !m_match_prev;
            m_match_prev = mn;

            if (mode_req_valid && int'(slot_sel) < NSLOT &&
                (m_settle || int'(mode_req) != m_mode || int'(slot_sel) != m_slot)) begin
                m_settle = 1; m_left = SETTLE;
                m_target = int'(mode_req); m_slot = int'(slot_sel);
            end else if (m_settle) begin
                m_left--;
                if (m_left == 0) begin
                    m_settle = 0; m_mode = m_target; ack = 1;
                end
            end

            if (refresh_limits && int'(slot_sel) < NSLOT) begin
                for (int d = 0; d < DIGITS; d++) begin
                    dig = int'(cnt_in[4*d +: 4]);
                    lim[slot_sel][d] = (dig > 9) ? 9 : dig;
                end
            end

            e.a = ack;
            if (!m_settle) begin
                case (m_mode)
                    1: begin
                        e.c = 1;
                        for (int d = 0; d < DIGITS; d++)
                            if (lim[m_slot][d] != 0) e.mo[4*d] = 1'b1;
                    end
                    2: begin e.m = 1; e.mo = lim_val(m_slot); end
                    3: begin e.s = 1; e.mo = lim_val(m_slot); end
                    default: ;
                endcase
            end
            sb.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t got, e;
        got = {max_out, carry_en, max_en, stop_en, mode_ack, limit_hit};
        if (!reset_n) begin
            checks++;
            if (got != '0) begin
                errors++;
                $display("FAIL reset_outputs got=%h want=0", got);
            end
        end else if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow got=%h want=<queued entry>", got);
        end else begin
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL sb_cycle t=%0t got mo=%h c%b m%b s%b a%b h%b want mo=%h c%b m%b s%b a%b h%b",
                         $time, got.mo, got.c, got.m, got.s, got.a, got.h,
                         e.mo, e.c, e.m, e.s, e.a, e.h);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic idle();
        refresh_limits = 0; mode_req_valid = 0;
    endtask

    task automatic request(input logic [1:0] m, input logic [0:0] s);
        mode_req = m; slot_sel = s; mode_req_valid = 1;
    endtask

    int hits, hit_idx, acks;
    logic [23:0] seq [5];

    initial begin
        reset_n = 0; cnt_in = '0; refresh_limits = 0; slot_sel = '0;
        mode_req_valid = 0; mode_req = 2'b00;
        repeat (3) tick();
        reset_n = 1;

        // 1: run MAX with a nonzero limit, then async reset mid-cycle
        cnt_in = 24'h000345; slot_sel = 0; refresh_limits = 1;
        tick(); idle();
        request(2'b10, 0); tick(); idle();
        tick(); tick();
        check("pre_reset_max_out", 32'(max_out), 32'h000345);
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        check("async_reset_max_out", 32'(max_out), 32'h0);
        check("async_reset_en", 32'({carry_en, max_en, stop_en}), 32'h0);
        tick(); tick();
        reset_n = 1;
        request(2'b10, 0); tick(); idle();
        tick(); tick();
        check("s1_max_en", 32'(max_en), 32'h1);
        check("s1_max_out", 32'(max_out), 32'h000000);
        check("s1_ack", 32'(mode_ack), 32'h1);

        // 2: carry mode from limit 0x000105
        cnt_in = 24'h000105; slot_sel = 0; refresh_limits = 1;
        tick(); idle();
        request(2'b01, 0); tick(); idle();
        check("s2_settle1", 32'({max_out, carry_en, max_en, stop_en, mode_ack}), 32'h0);
        tick();
        check("s2_settle2", 32'({max_out, carry_en, max_en, stop_en, mode_ack}), 32'h0);
        tick();
        check("s2_carry_en", 32'(carry_en), 32'h1);
        check("s2_max_out", 32'(max_out), 32'h000101);
        check("s2_ack", 32'(mode_ack), 32'h1);
        tick();
        check("s2_ack_pulse", 32'(mode_ack), 32'h0);

        // 3: clamped capture into slot1 together with MAX request on slot1
        cnt_in = 24'h0000A3; refresh_limits = 1; request(2'b10, 1);
        tick(); idle(); cnt_in = '0;
        tick(); tick();
        check("s3_max_out", 32'(max_out), 32'h000093);
        check("s3_en", 32'({carry_en, max_en, stop_en}), 32'b010);

        // 4: STOP on 0x000012, one limit_hit after first match
        cnt_in = 24'h000012; slot_sel = 0; refresh_limits = 1;
        tick(); idle(); cnt_in = '0;
        request(2'b11, 0); tick(); idle();
        tick(); tick();
        check("s4_stop_en", 32'(stop_en), 32'h1);
        seq[0] = 24'h10; seq[1] = 24'h11; seq[2] = 24'h12; seq[3] = 24'h12; seq[4] = 24'h13;
        hits = 0; hit_idx = -1;
        for (int i = 0; i < 6; i++) begin
            cnt_in = (i < 5) ? seq[i] : 24'h13;
            tick();
            if (limit_hit) begin
                hits++;
                if (hit_idx < 0) hit_idx = i;
            end
        end
        check("s4_hit_count", 32'(hits), 32'd1);
        check("s4_hit_cycle", 32'(hit_idx), 32'd2);

        // 5: retarget during SETTLE
        acks = 0;
        request(2'b10, 0); tick();
        acks += int'(mode_ack);
        request(2'b11, 0); tick(); idle();
        acks += int'(mode_ack);
        check("s5_low1", 32'({max_out, carry_en, max_en, stop_en}), 32'h0);
        tick();
        acks += int'(mode_ack);
        check("s5_low2", 32'({max_out, carry_en, max_en, stop_en}), 32'h0);
        tick();
        acks += int'(mode_ack);
        check("s5_stop_en", 32'({carry_en, max_en, stop_en}), 32'b001);
        tick();
        acks += int'(mode_ack);
        check("s5_ack_count", 32'(acks), 32'd1);

        // 6: repeat of the current mode and slot is ignored
        request(2'b11, 0); tick(); idle();
        check("s6_stop_kept", 32'(stop_en), 32'h1);
        check("s6_no_ack", 32'(mode_ack), 32'h0);
        tick();
        check("s6_no_ack2", 32'(mode_ack), 32'h0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            mode_req_valid = ($urandom_range(0, 7) == 0);
            mode_req       = 2'($urandom_range(0, 3));
            slot_sel       = 1'($urandom_range(0, 1));
            refresh_limits = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) cnt_in = 24'($urandom);
            else cnt_in = lim_val($urandom_range(0, NSLOT - 1));
            tick();
        end
        idle();
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
